// File: rtl/wb_timer.sv
// wb_timer: Wishbone slave timer/compare unit with a prescaled 32-bit
// counter, compare match, overflow, sticky flags and a maskable irq.
//
// Ports:
//   clk_i       system clock, all logic on the rising edge
//   rst_i       synchronous active-high reset
//   wb_cyc_i    bus cycle
//   wb_stb_i    strobe
//   wb_we_i     write enable
//   wb_adr_i    byte address, only [4:2] decoded
//   wb_dat_i    write data
//   wb_sel_i    byte lane enables for writes
//   wb_dat_o    read data, valid with wb_ack_o
//   wb_ack_o    acknowledge, one cycle after each accepted request
//   wb_stall_o  tied 0
//   wb_err_o    tied 0
//   irq_o       registered level interrupt request
//
// Register map (wb_adr_i[4:2]):
//   0 CTRL   bit0 EN, bit1 AUTOCLR, bit2 MIE, bit3 OIE
//   1 PRESC  [PRESC_W-1:0]
//   2 COUNT
//   3 CMP
//   4 STATUS bit0 MF, bit1 OF (write-1-to-clear)
//   5..7     read 0, writes ignored

module wb_timer #(
    parameter int          PRESC_W = 16,
    parameter logic [31:0] RST_CMP = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_stall_o,
    output logic        wb_err_o,
    output logic        irq_o
);

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_PRESC  = 3'd1;
    localparam logic [2:0] A_COUNT  = 3'd2;
    localparam logic [2:0] A_CMP    = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;

    // Architectural state
    logic [3:0]         ctrl;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] pcnt;
    logic [31:0]        count;
    logic [31:0]        cmp;
    logic               mf;
    logic               of;

    // Control field aliases
    logic en;
    logic autoclr;
    logic mie;
    logic oie;

    assign en      = ctrl[0];
    assign autoclr = ctrl[1];
    assign mie     = ctrl[2];
    assign oie     = ctrl[3];

    // Bus decode
    logic       req;
    logic       wr;
    logic [2:0] reg_sel;

    assign req     = wb_cyc_i & wb_stb_i;
    assign reg_sel = wb_adr_i[4:2];

    // A write with no byte lanes enabled is acked but has no side effects,
    // including the prescaler clear on a PRESC write.
    assign wr = req & wb_we_i & (|wb_sel_i);

    logic ctrl_wr;
    logic presc_wr;
    logic count_wr;
    logic cmp_wr;
    logic status_wr;

    assign ctrl_wr   = wr & (reg_sel == A_CTRL);
    assign presc_wr  = wr & (reg_sel == A_PRESC);
    assign count_wr  = wr & (reg_sel == A_COUNT);
    assign cmp_wr    = wr & (reg_sel == A_CMP);
    assign status_wr = wr & (reg_sel == A_STATUS);

    assign wb_stall_o = 1'b0;
    assign wb_err_o   = 1'b0;

    // Byte-lane merge of write data into an existing register value
    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] nw,
        input logic [3:0]  sel
    );
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = sel[i] ? nw[8*i +: 8] : old[8*i +: 8];
        end
        return m;
    endfunction

    logic [31:0] ctrl_new;
    logic [31:0] presc_new;
    logic [31:0] count_new;
    logic [31:0] cmp_new;

    always_comb begin
        ctrl_new  = merge({28'd0, ctrl}, wb_dat_i, wb_sel_i);
        presc_new = merge(32'(presc), wb_dat_i, wb_sel_i);
        count_new = merge(count, wb_dat_i, wb_sel_i);
        cmp_new   = merge(cmp, wb_dat_i, wb_sel_i);
    end

    // STATUS clears only act on lanes that are enabled
    logic mf_clr;
    logic of_clr;

    assign mf_clr = status_wr & wb_sel_i[0] & wb_dat_i[0];
    assign of_clr = status_wr & wb_sel_i[0] & wb_dat_i[1];

    // Prescaler: tick in the cycle the counter reaches PRESC
    logic               tick;
    logic [PRESC_W-1:0] pcnt_nxt;

    assign tick = en & (pcnt == presc);

    always_comb begin
        pcnt_nxt = pcnt;
        if (presc_wr) begin
            pcnt_nxt = '0;
        end else if (en) begin
            pcnt_nxt = tick ? '0 : pcnt + PRESC_W'(1);
        end
    end

    // Counter update. A bus write to COUNT masks the tick entirely, so
    // neither match nor overflow is evaluated in that cycle. On a match
    // with COUNT at its maximum, count+1 wraps to 0, which is exactly the
    // required result whether or not AUTOCLR is set.
    logic [31:0] count_nxt;
    logic        mf_set;
    logic        of_set;

    always_comb begin
        count_nxt = count;
        mf_set    = 1'b0;
        of_set    = 1'b0;
        if (count_wr) begin
            count_nxt = count_new;
        end else if (tick) begin
            mf_set    = (count == cmp);
            of_set    = (count == CNT_MAX);
            count_nxt = (mf_set && autoclr) ? 32'd0 : count + 32'd1;
        end
    end

    // Read mux, sampled at acceptance
    logic [31:0] rdata;

    always_comb begin
        rdata = 32'd0;
        case (reg_sel)
            A_CTRL:   rdata = {28'd0, ctrl};
            A_PRESC:  rdata = 32'(presc);
            A_COUNT:  rdata = count;
            A_CMP:    rdata = cmp;
            A_STATUS: rdata = {30'd0, of, mf};
            default:  rdata = 32'd0;
        endcase
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl  <= 4'd0;
            presc <= '0;
            pcnt  <= '0;
            count <= 32'd0;
            cmp   <= RST_CMP;
            mf    <= 1'b0;
            of    <= 1'b0;
        end else begin
            pcnt  <= pcnt_nxt;
            count <= count_nxt;
            if (ctrl_wr) begin
                ctrl <= ctrl_new[3:0];
            end
            if (presc_wr) begin
                presc <= presc_new[PRESC_W-1:0];
            end
            if (cmp_wr) begin
                cmp <= cmp_new;
            end
            // A flag being set beats a simultaneous write-1-to-clear
            mf <= mf_set | (mf & ~mf_clr);
            of <= of_set | (of & ~of_clr);
        end
    end

    // Bus response and interrupt
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 32'd0;
            irq_o    <= 1'b0;
        end else begin
            wb_ack_o <= req;
            wb_dat_o <= req ? rdata : 32'd0;
            irq_o    <= (mf & mie) | (of & oie);
        end
    end

    // Address bits outside [4:2] are not decoded; the upper bits of the
    // merged CTRL/PRESC words are not stored.
    logic unused;

    assign unused = ^{wb_adr_i[31:5], wb_adr_i[1:0],
                      ctrl_new[31:4], presc_new};

endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer: scoreboard bench for wb_timer.
// Reads push expected data at issue; the ack monitor pops and compares.

module tb_wb_timer;

    logic        clk;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic [31:0] dat_r;
    logic        ack;
    logic        stall;
    logic        err;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        we;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];

    wb_timer #(
        .PRESC_W(16),
        .RST_CMP(32'hFFFF_FFFF)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_we_i   (we),
        .wb_adr_i  (adr),
        .wb_dat_i  (dat_w),
        .wb_sel_i  (sel),
        .wb_dat_o  (dat_r),
        .wb_ack_o  (ack),
        .wb_stall_o(stall),
        .wb_err_o  (err),
        .irq_o     (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Ack monitor: every accepted request (not under reset) must be
    // acked on the next edge; reads are scored against the queue.
    always @(posedge clk) begin
        logic acc;
        exp_t e;
        acc = cyc & stb & ~rst;
        #1;
        check("ack", {31'd0, ack}, {31'd0, acc});
        check("stall_err", {30'd0, stall, err}, 32'd0);
        if (ack) begin
            if (sb.size() == 0) begin
                check("spurious_ack", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                if (!e.we) begin
                    check(e.tag, dat_r, e.exp);
                end
            end
        end
    end

    // Drive one request for the coming edge (caller is at a negedge)
    task automatic bus(input logic w, input int a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] e, input string t);
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = w;
        adr   = 32'(a) << 2;
        dat_w = d;
        sel   = s;
        if (!rst) begin
            sb.push_back('{w, e, t});
        end
    endtask

    task automatic wrs(input int a, input logic [31:0] d,
                       input logic [3:0] s);
        @(negedge clk);
        bus(1'b1, a, d, s, 32'd0, "wr");
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        wrs(a, d, 4'hF);
    endtask

    task automatic rd(input int a, input logic [31:0] e,
                      input string t);
        @(negedge clk);
        bus(1'b0, a, 32'd0, 4'h0, e, t);
    endtask

    task automatic nop(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc = 1'b0;
            stb = 1'b0;
            we  = 1'b0;
        end
    endtask

    logic [31:0] rst_tab [8];
    logic [31:0] seq_tab [8];
    logic [31:0] st_tab  [4];

    initial begin
        rst   = 1'b1;
        cyc   = 1'b0;
        stb   = 1'b0;
        we    = 1'b0;
        adr   = 32'd0;
        dat_w = 32'd0;
        sel   = 4'h0;

        rst_tab = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF,
                    32'd0, 32'd0, 32'd0, 32'd0};
        seq_tab = '{32'd0, 32'd1, 32'd2, 32'd3,
                    32'd4, 32'd5, 32'd0, 32'd1};
        st_tab  = '{32'd0, 32'd0, 32'd2, 32'd3};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_dat", dat_r, 32'd0);

        // Reset values, back-to-back reads
        for (int i = 0; i < 8; i++) begin
            rd(i, rst_tab[i], $sformatf("rst_rd%0d", i));
        end

        // Prescaler 3: one count per 4 ticks
        wr(1, 32'd3);
        wr(0, 32'd1);
        nop(40);
        rd(2, 32'd10, "presc_count");
        wr(0, 32'd0);
        nop(5);
        rd(2, 32'd10, "hold_count");

        // Match with autoclear and MIE
        wr(1, 32'd0);
        wr(3, 32'd5);
        wr(2, 32'd0);
        wr(4, 32'd3);
        wr(0, 32'd7);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("m_irq%0d", k), {31'd0, irq},
                  {31'd0, (k >= 8)});
            bus(1'b0, 2, 32'd0, 4'h0, seq_tab[k-1],
                $sformatf("m_cnt%0d", k));
        end
        rd(4, 32'd1, "m_status");
        wr(4, 32'd1);
        nop(1);
        check("m_irq_hold", {31'd0, irq}, 32'd1);
        nop(1);
        check("m_irq_clr", {31'd0, irq}, 32'd0);
        wr(0, 32'd0);

        // Overflow with OIE, then MF alone
        wr(1, 32'd0);
        wr(3, 32'd0);
        wr(2, 32'hFFFF_FFFE);
        wr(4, 32'd3);
        wr(0, 32'd9);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("o_irq%0d", k), {31'd0, irq},
                  {31'd0, (k == 4)});
            bus(1'b0, 4, 32'd0, 4'h0, st_tab[k-1],
                $sformatf("o_st%0d", k));
        end
        rd(2, 32'd2, "o_count");
        wr(4, 32'd2);
        nop(1);
        nop(1);
        check("o_irq_mf_only", {31'd0, irq}, 32'd0);
        rd(4, 32'd1, "o_mf_only");
        wr(0, 32'd0);

        // Byte lanes, zero-sel write, field widths
        wr(3, 32'd0);
        wrs(3, 32'hAABB_CCDD, 4'b0101);
        rd(3, 32'h00BB_00DD, "lane_cmp");
        wrs(3, 32'h1234_5678, 4'b0000);
        rd(3, 32'h00BB_00DD, "sel0_cmp");
        wr(1, 32'hFFFF_FFFF);
        rd(1, 32'h0000_FFFF, "presc_w");
        wr(0, 32'hFFFF_FFF2);
        rd(0, 32'd2, "ctrl_w");
        wr(5, 32'hFFFF_FFFF);
        rd(5, 32'd0, "hole5");
        wr(0, 32'd0);

        // COUNT write collides with a matching tick
        wr(1, 32'd0);
        wr(2, 32'd7);
        wr(3, 32'd7);
        wr(4, 32'd3);
        wr(0, 32'd1);
        wr(2, 32'd123);
        rd(2, 32'd123, "coll_count");
        rd(4, 32'd0, "coll_nomf");
        wr(0, 32'd0);

        // W1C of MF collides with a match
        wr(3, 32'd10);
        wr(2, 32'd10);
        wr(4, 32'd3);
        wr(0, 32'd1);
        wr(4, 32'd1);
        rd(4, 32'd1, "w1c_set_wins");
        wr(0, 32'd4);
        nop(2);
        check("pre_rst_irq", {31'd0, irq}, 32'd1);

        // Reset with a request in flight
        @(negedge clk);
        rst = 1'b1;
        bus(1'b0, 3, 32'd0, 4'h0, 32'd0, "rst_req");
        @(negedge clk);
        rst = 1'b0;
        cyc = 1'b0;
        stb = 1'b0;
        check("rst_ack_drop", {31'd0, ack}, 32'd0);
        check("rst2_dat", dat_r, 32'd0);
        check("rst2_irq", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            rd(i, rst_tab[i], $sformatf("rst2_rd%0d", i));
        end

        // Strobe without cycle is not a request
        @(negedge clk);
        cyc = 1'b0;
        stb = 1'b1;
        we  = 1'b0;
        nop(3);
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_timer.md
Name: wb_timer

Overview:
- Wishbone slave timer/compare unit that generates the interrupt request for the picorv32 core.
- Sits on the wbxbar as one slave port; its irq output drives one bit of the core's irq vector.
- Gives firmware (bootloader, UART polling timeouts, scheduling) a prescaled free-running 32-bit counter.
- The counter has a compare match and overflow, with sticky flags and a maskable interrupt.

Parameters:
- PRESC_W, 16, width of prescaler register and prescaler counter (1..32).
- RST_CMP, 32'hFFFFFFFF, reset value of CMP register.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  32  byte address; only [4:2] decoded.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte lane enables for writes.
- wb_dat_o  out  32  read data, valid with wb_ack_o.
- wb_ack_o  out  1  acknowledge.
- wb_stall_o  out  1  tied 0.
- wb_err_o  out  1  tied 0.
- irq_o  out  1  level interrupt request, registered.

Behaviour:
- Register map, offsets from wb_adr_i[4:2]:
  - 0 CTRL: bit0 EN, bit1 AUTOCLR, bit2 MIE (match irq enable), bit3 OIE (overflow irq enable); other bits read 0.
  - 1 PRESC: [PRESC_W-1:0].
  - 2 COUNT.
  - 3 CMP.
  - 4 STATUS: bit0 MF (match flag), bit1 OF (overflow flag); write-1-to-clear.
  - 5..7: read 0, writes ignored, still acked.
- Reset values: CTRL=0, PRESC=0, prescaler counter=0, COUNT=0, CMP=RST_CMP, STATUS=0, wb_ack_o=0, wb_dat_o=0, irq_o=0.
- Bus handshake:
  - A request is wb_cyc_i&wb_stb_i. wb_stall_o=0, so a request is accepted every cycle (back-to-back allowed).
  - wb_ack_o is asserted exactly one cycle after each accepted request, for one cycle. wb_dat_o holds the read value for that cycle, sampled at acceptance.
  - Writes commit at the acceptance edge, byte lanes per wb_sel_i. A write with wb_sel_i=0 changes nothing but is acked.
  - If wb_cyc_i drops, no ack is generated for a request not yet accepted. An ack already scheduled is still emitted.
- Prescaler:
  - While EN=1, the prescaler counter increments each cycle.
  - When it equals PRESC it returns to 0 and generates tick for that cycle. PRESC=0 gives a tick every cycle; PRESC=N gives a tick every N+1 cycles.
  - EN=0 holds both the prescaler counter and COUNT.
  - Any write to PRESC clears the prescaler counter.
- COUNT update on tick:
  - If COUNT==CMP: set MF; COUNT <= AUTOCLR ? 0 : COUNT+1.
  - Else if COUNT==32'hFFFFFFFF: COUNT <= 0 and set OF.
  - Else COUNT <= COUNT+1.
  - When CMP=FFFFFFFF and COUNT=FFFFFFFF: both MF and OF set; next COUNT is 0 regardless of AUTOCLR.
- Simultaneous events:
  - Bus write to COUNT in the same cycle as a tick: bus write wins; no match/overflow evaluated that cycle.
  - STATUS W1C in the same cycle as a flag set: set wins, flag stays 1.
  - CMP write takes effect for comparisons from the next cycle.
- irq_o is a register: irq_o <= (MF&MIE)|(OF&OIE). It rises one cycle after the enabling flag or mask bit is visible, and falls one cycle after the clear.
- Reset mid-operation, including a pending ack: all state returns to reset values at that edge; the pending ack is dropped.

Test Plan:
- Reset, then read all offsets 0..7 -> values 0,0,0,FFFFFFFF,0,0,0,0. Each ack arrives 1 cycle after stb; stall/err always 0.
- PRESC=3, CMP=FFFFFFFF, CTRL=1, wait 40 cycles, then read COUNT -> COUNT has advanced by one per 4 cycles; 40 cycles from EN gives 10 (±1 for bus latency).
- PRESC=0, CMP=5, CTRL=7 (EN, AUTOCLR, MIE) -> COUNT sequence 0..5,0,1..; MF=1 at the first tick with COUNT==5; irq_o high 1 cycle later. Write STATUS=1 -> irq_o low 1 cycle after (unless re-matched).
- COUNT=FFFFFFFE, CMP=0, CTRL=9 (EN, OIE), PRESC=0 -> after 2 ticks COUNT=0 and OF=1, irq_o=1. Since CMP=0, MF is set on the following tick. MF alone does not raise irq_o (MIE=0).
- Byte-lane write: CMP=0, write dat=AABBCCDD with sel=4'b0101 to CMP -> CMP reads 00BB00DD. Back-to-back write then read of the same register in consecutive cycles -> read returns the new value.
- Collisions: force a tick and a COUNT write of 123 in the same cycle -> COUNT=123. Force a W1C of MF in the same cycle as a match -> MF remains 1. Assert rst_i while an ack is pending -> no ack next cycle, all registers at reset values.
